// File: rtl/prog_loader.sv
// prog_loader: UART boot loader that streams a length-prefixed
// program image into instruction memory while holding the CPU.
module prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE,
        L_HDR0,
        L_HDR1,
        L_DATA,
        L_DONE,
        L_ERR
    } ld_state_t;

    logic        rx_s1, rx_s2, rx_prev;
    rx_state_t   rs, rs_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  rx_byte, sh_nxt;
    logic        byte_valid, bv_nxt;
    logic        frame_err, fe_nxt;

    ld_state_t   st, st_nxt;
    logic        go;
    logic [15:0] n;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [ADDR_W-1:0] addr;
    logic [23:0] acc;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] hdr_n;
    logic        last_word;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs         <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rs         <= rs_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_nxt;
            rx_byte    <= sh_nxt;
            byte_valid <= bv_nxt;
            frame_err  <= fe_nxt;
        end
    end

    // Receiver next state: mid-bit sampling, false-start rejection
    always_comb begin
        rs_nxt  = rs;
        cnt_nxt = cnt;
        bit_nxt = bit_idx;
        sh_nxt  = rx_byte;
        bv_nxt  = 1'b0;
        fe_nxt  = 1'b0;
        case (rs)
            R_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rs_nxt  = R_START;
                    cnt_nxt = '0;
                end
            end
            R_START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt = '0;
                    bit_nxt = '0;
                    rs_nxt  = rx_s2 ? R_IDLE : R_DATA;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            R_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rx_s2, rx_byte[7:1]};
                    bit_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        rs_nxt = R_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            R_STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt = '0;
                    rs_nxt  = R_IDLE;
                    bv_nxt  = rx_s2;
                    fe_nxt  = !rx_s2;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: rs_nxt = R_IDLE;
        endcase
    end

    assign hdr_n     = {16'd0, rx_byte, n[7:0]};
    assign last_word = ({1'b0, word_cnt} + 17'd1) == {1'b0, n};

    // Loader state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= L_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // Loader next state and start decode
    always_comb begin
        st_nxt = st;
        go     = 1'b0;
        case (st)
            L_IDLE, L_DONE, L_ERR: begin
                if (start) begin
                    go     = 1'b1;
                    st_nxt = L_HDR0;
                end
            end
            L_HDR0: begin
                if (frame_err) begin
                    st_nxt = L_ERR;
                end else if (byte_valid) begin
                    st_nxt = L_HDR1;
                end
            end
            L_HDR1: begin
                if (frame_err) begin
                    st_nxt = L_ERR;
                end else if (byte_valid) begin
                    if (hdr_n == 32'd0) begin
                        st_nxt = L_DONE;
                    end else if (hdr_n > (32'd1 << ADDR_W)) begin
                        st_nxt = L_ERR;
                    end else begin
                        st_nxt = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (frame_err) begin
                    st_nxt = L_ERR;
                end else if (we && last_word) begin
                    st_nxt = L_DONE;
                end
            end
            default: st_nxt = L_IDLE;
        endcase
    end

    // Header capture, little-endian word assembly and write strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n        <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            addr     <= '0;
            acc      <= '0;
            wdata    <= '0;
            we       <= 1'b0;
        end else begin
            we <= 1'b0;
            if (go) begin
                word_cnt <= '0;
                byte_idx <= '0;
                addr     <= '0;
            end
            if (st == L_HDR0 && byte_valid) begin
                n[7:0] <= rx_byte;
            end
            if (st == L_HDR1 && byte_valid) begin
                n[15:8] <= rx_byte;
            end
            if (st == L_DATA && byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: acc[7:0]   <= rx_byte;
                    2'd1: acc[15:8]  <= rx_byte;
                    2'd2: acc[23:16] <= rx_byte;
                    default: begin
                        wdata <= {rx_byte, acc};
                        we    <= 1'b1;
                    end
                endcase
            end
            if (we) begin
                addr     <= addr + 1'b1;
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end

    assign imem_we    = we;
    assign imem_addr  = addr;
    assign imem_wdata = wdata;
    assign busy       = (st == L_HDR0) || (st == L_HDR1) || (st == L_DATA);
    assign done       = (st == L_DONE);
    assign err        = (st == L_ERR);
    assign cpu_hold   = busy || err;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: UART-driven scenarios for prog_loader with a
// write scoreboard fed by the stimulus tasks.
module tb_prog_loader;

    localparam int CPB = 16;
    localparam int AW  = 4;

    logic          clk;
    logic          rst;
    logic          rx;
    logic          start;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_tests;
    int  n_fail;
    int  n_writes;

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .start(start),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every write-strobe cycle consumes one expected write
    always @(negedge clk) begin
        if (rst && imem_we) begin
            n_writes++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%0d data=%h",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL write got=%0d:%h want=%0d:%h",
                             imem_addr, imem_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w);
        exp_q.push_back('{addr: a, data: w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 1'b1);
        end
    endtask

    task automatic glitch();
        rx = 1'b0;
        repeat (CPB / 2 - 3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (done || err) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx = 1'b1;
        start = 1'b0;
        #1;
        n_tests++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got we=%b a=%0d d=%h h=%b b=%b d=%b e=%b want all 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b hold=%b want 0 0", busy, cpu_hold);
        end
    endtask

    task automatic test_glitch();
        bit to;
        int w0;
        w0 = n_writes;
        glitch();
        n_tests++;
        if ({busy, done, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL glitch_idle got bde=%b want 000", {busy, done, err});
        end
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        glitch();
        exp_q.push_back('{addr: 4'd0, data: 32'hDEADBEEF});
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        glitch();
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        wait_end(to);
        n_tests++;
        if (to || done !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_load got done=%b err=%b want 1 0", done, err);
        end
        n_tests++;
        if (n_writes - w0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_writes got %0d left=%0d want 1 0",
                     n_writes - w0, exp_q.size());
        end
    endtask

    task automatic test_basic_load();
        bit to;
        int w0;
        w0 = n_writes;
        pulse_start();
        n_tests++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hdr0 got b=%b h=%b d=%b want 1 1 0", busy, cpu_hold, done);
        end
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(4'd0, 32'h00A00513);
        send_word(4'd1, 32'h00100593);
        wait_end(to);
        n_tests++;
        if (to || done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done got d=%b h=%b e=%b want 1 0 0", done, cpu_hold, err);
        end
        n_tests++;
        if (n_writes - w0 != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_writes got %0d left=%0d want 2 0",
                     n_writes - w0, exp_q.size());
        end
        n_tests++;
        if (imem_addr !== 4'd2 || imem_wdata !== 32'h00100593) begin
            n_fail++;
            $display("FAIL basic_hold got a=%0d d=%h want 2 00100593", imem_addr, imem_wdata);
        end
    endtask

    task automatic test_zero_len();
        bit to;
        int w0;
        w0 = n_writes;
        pulse_start();
        send_byte(8'h00, 1'b1);
        n_tests++;
        if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_hdr1 got h=%b b=%b want 1 1", cpu_hold, busy);
        end
        send_byte(8'h00, 1'b1);
        wait_end(to);
        n_tests++;
        if (to || done !== 1'b1 || cpu_hold !== 1'b0 || n_writes != w0) begin
            n_fail++;
            $display("FAIL zero_done got d=%b h=%b w=%0d want 1 0 0",
                     done, cpu_hold, n_writes - w0);
        end
    endtask

    task automatic test_too_long();
        bit to;
        int w0;
        w0 = n_writes;
        pulse_start();
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_end(to);
        n_tests++;
        if (to || err !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL toolong_err got e=%b h=%b b=%b d=%b want 1 1 0 0",
                     err, cpu_hold, busy, done);
        end
        n_tests++;
        if (n_writes != w0) begin
            n_fail++;
            $display("FAIL toolong_writes got %0d want 0", n_writes - w0);
        end
        pulse_start();
        n_tests++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL toolong_recover got b=%b e=%b want 1 0", busy, err);
        end
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_end(to);
        n_tests++;
        if (to || done !== 1'b1) begin
            n_fail++;
            $display("FAIL toolong_reload got done=%b want 1", done);
        end
    endtask

    task automatic test_max_len();
        bit to;
        int w0;
        w0 = n_writes;
        pulse_start();
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_word(AW'(i), $urandom);
        end
        wait_end(to);
        n_tests++;
        if (to || done !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL maxlen_done got d=%b e=%b want 1 0", done, err);
        end
        n_tests++;
        if (n_writes - w0 != 16 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL maxlen_writes got %0d left=%0d want 16 0",
                     n_writes - w0, exp_q.size());
        end
    endtask

    task automatic test_frame_err();
        bit to;
        int w0;
        w0 = n_writes;
        pulse_start();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'hA0, 1'b0);
        wait_end(to);
        n_tests++;
        if (to || err !== 1'b1 || cpu_hold !== 1'b1 || imem_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL ferr_state got e=%b h=%b a=%0d want 1 1 0",
                     err, cpu_hold, imem_addr);
        end
        send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        n_tests++;
        if (n_writes != w0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_writes got w=%0d e=%b want 0 1", n_writes - w0, err);
        end
    endtask

    task automatic test_back_to_back_after_reset();
        bit to;
        int w0;
        logic [31:0] w;
        w0 = n_writes;
        pulse_start();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(4'd0, $urandom);
        w = $urandom;
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs got a=%0d d=%h h=%b b=%b want 0",
                     imem_addr, imem_wdata, cpu_hold, busy);
        end
        n_tests++;
        if (n_writes - w0 != 1) begin
            n_fail++;
            $display("FAIL midrst_prewrites got %0d want 1", n_writes - w0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        w0 = n_writes;
        pulse_start();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(4'd0, $urandom);
        send_word(4'd1, $urandom);
        wait_end(to);
        n_tests++;
        if (to || done !== 1'b1 || n_writes - w0 != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_reload got d=%b w=%0d left=%0d want 1 2 0",
                     done, n_writes - w0, exp_q.size());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        n_writes = 0;
        test_reset();
        test_glitch();
        test_basic_load();
        test_zero_len();
        test_too_long();
        test_max_len();
        test_frame_err();
        test_back_to_back_after_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
